// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port sync RAM between fetch (if_*) and load/store (d_*), data first, fetch anti-starvation.
// Latency: grant is combinational in the request cycle; read data returns exactly one cycle after the grant.
// Backpressure: an ungranted requester holds req/addr/wdata; stall_if/stall_d flag the denied requester.
module mem_port_arbiter #(
  parameter int MEM_AW   = 12,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_d_o
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic       if_gnt, d_gnt;

  // Address bits outside the RAM word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:MEM_AW+2], if_addr_i[1:0],
                              d_addr_i[31:MEM_AW+2], d_addr_i[1:0]};

  // Arbitration: data wins unless fetch has waited MAX_WAIT cycles; nothing is granted while in reset.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_ni) begin
      if (if_req_i && (!d_req_i || (wait_cnt_q == MAX_WAIT_C))) begin
        if_gnt = 1'b1;
      end else if (d_req_i) begin
        d_gnt = 1'b1;
      end
    end
  end

  // RAM drive follows the winner; idle cycles park address/wdata at zero.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (if_gnt) begin
      mem_addr_o = if_addr_i[MEM_AW+1:2];
    end else if (d_gnt) begin
      mem_addr_o  = d_addr_i[MEM_AW+1:2];
      mem_we_o    = d_we_i;
      mem_wdata_o = d_wdata_i;
    end
  end

  // Next-state for the starvation counter and the outstanding-read owner.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (if_gnt || !if_req_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    rd_owner_d = OWN_NONE;
    if (if_gnt) begin
      rd_owner_d = OWN_IF;
    end else if (d_gnt && !d_we_i) begin
      rd_owner_d = OWN_D;
    end
  end

  // State registers; reset drops any outstanding read so no rvalid follows reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign d_gnt_o     = d_gnt;
  assign stall_if_o  = if_req_i & ~if_gnt;
  assign stall_d_o   = d_req_i & ~d_gnt;
  assign if_rvalid_o = (rd_owner_q == OWN_IF);
  assign d_rvalid_o  = (rd_owner_q == OWN_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'd0;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'd0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous instruction/data RAM between the core's fetch stage and its load/store stage.
- Grants at most one access per cycle. The data port has priority.
- A starvation counter guarantees forward progress for fetch.
- Tracks the owner of the one outstanding read and routes the returning read word plus a valid strobe back to that requester.
- Sits between the pc/fetch logic and the memory block; its non-grant doubles as the pipeline stall.

Parameters:
- MEM_AW, 12: RAM word-address width; RAM word index = byte_addr[MEM_AW+1:2].
- MAX_WAIT, 4: consecutive denied fetch cycles before fetch is forced ahead of data; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req  input  1  fetch read request.
- if_addr  input  32  fetch byte address.
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  if_rdata valid this cycle.
- if_rdata  output  32  fetched instruction word.
- d_req  input  1  load/store request.
- d_we  input  1  1=store, 0=load.
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  d_rdata valid this cycle.
- d_rdata  output  32  load data.
- mem_addr  output  MEM_AW  RAM word address.
- mem_we  output  1  RAM write enable.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data, valid one cycle after the address.
- stall_if  output  1  equals if_req & ~if_gnt.
- stall_d  output  1  equals d_req & ~d_gnt.

Behaviour:
- Reset (rst_n=0, async):
  - Clears wait_cnt to 0 and rd_owner to NONE.
  - All grants, rvalids and mem_we are 0.
  - if_rdata and d_rdata are 0.
  - mem_addr and mem_wdata are 0.
  - Outputs hold these values for as long as rst_n=0.
- Arbitration is combinational, same cycle:
  - Only if_req: grant fetch.
  - Only d_req: grant data.
  - Both requesting: grant fetch if wait_cnt==MAX_WAIT, otherwise grant data.
  - Neither requesting: no grant, mem_we=0.
  - Exactly one grant per cycle at most.
- RAM drive:
  - Fetch granted: mem_addr=if_addr[MEM_AW+1:2], mem_we=0.
  - Data granted: mem_addr=d_addr[MEM_AW+1:2], mem_we=d_we, mem_wdata=d_wdata.
  - No grant: mem_addr holds 0 and mem_we=0.
  - Address bits [1:0] are ignored; no misalignment trap.
- wait_cnt, 4-bit register, updated each clock edge:
  - Resets to 0 when if_gnt=1 or if_req=0.
  - Otherwise increments, saturating at MAX_WAIT.
  - Result: after MAX_WAIT consecutive denied cycles, the next cycle is a fetch grant.
- rd_owner register (NONE/IF/D):
  - Loads IF on a fetch grant.
  - Loads D on a data grant with d_we=0.
  - Otherwise loads NONE.
  - Stores never produce rvalid; d_gnt is the store's completion.
- Response, the cycle after the grant:
  - rd_owner==IF: if_rvalid=1 and if_rdata=mem_rdata.
  - rd_owner==D: d_rvalid=1 and d_rdata=mem_rdata.
  - Any rdata whose rvalid is 0 is driven 0.
- Latency and throughput:
  - Read latency is exactly 1 cycle from grant.
  - Back-to-back grants to the same or alternating requesters are allowed every cycle (full throughput).
- Requester rule: a requester holds req, addr and wdata stable until it sees gnt. The arbiter does not latch ungranted requests.
- Reset mid-read: an outstanding read is dropped and no rvalid appears after reset is released.

Test Plan:
- Reset: hold rst_n=0 with if_req=d_req=1 → all grants/rvalid/mem_we=0, rdata=0. Release → if_gnt=0, d_gnt=1 in the first cycle.
- Fetch alone: if_req=1, if_addr=0x40, RAM word 0x10=0xDEADBEEF → if_gnt=1 and mem_addr=0x10 in cycle 0; if_rvalid=1 and if_rdata=0xDEADBEEF in cycle 1; d_rvalid=0.
- Store then load:
  - d_we=1, d_addr=0x100, d_wdata=0x12345678 → d_gnt=1, mem_we=1, mem_addr=0x40, no d_rvalid.
  - Next cycle, load 0x100 → d_rvalid=1 and d_rdata=0x12345678 one cycle after the grant.
- Starvation with MAX_WAIT=4:
  - Both requesting continuously → d_gnt on cycles 0-3, if_gnt on cycle 4, d_gnt on cycles 5-8, if_gnt on cycle 9.
  - stall_if=1 exactly on the denied fetch cycles.
- Alternating reads:
  - Cycle 0: fetch only at 0x0. Cycle 1: data load only at 0x8 → if_rvalid in cycle 1, d_rvalid in cycle 2, each with the correct RAM word.
  - A grant in every cycle, no bubbles.
- Reset mid-read: fetch granted in cycle 0, rst_n=0 asserted asynchronously during cycle 1 → if_rvalid drops to 0 immediately and stays 0 after release while no request is present.
